// File: rtl/pixel_addr_gen.sv
// Streams RAM word address + sub-word lane beats for a sprite pixel run or a text character run.
// Optional sprite bounds rejection is built when PIXEL_ADDR_GEN_BOUNDS_CHECK_EN is defined.
module pixel_addr_gen #(
    parameter int ADDR_W     = 26,
    parameter int WORD_BITS  = 16,
    parameter int PIXEL_BITS = 16,
    parameter int CHAR_BITS  = 8,
    parameter int DIM_W      = 16,
    parameter int LANE_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_sprite,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [7:0]        cmd_frame,
    input  logic [DIM_W-1:0]  cmd_height,
    input  logic [DIM_W-1:0]  cmd_width,
    input  logic [DIM_W-1:0]  cmd_x,
    input  logic [DIM_W-1:0]  cmd_y,
    input  logic [DIM_W-1:0]  cmd_index,
    input  logic [DIM_W-1:0]  cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_last,
    output logic              err
);
    localparam int PPW     = WORD_BITS / PIXEL_BITS;
    localparam int CPW     = WORD_BITS / CHAR_BITS;
    localparam int PPW_LOG = $clog2(PPW);
    localparam int CPW_LOG = $clog2(CPW);
    localparam int EXTRA   = (PPW_LOG > CPW_LOG) ? PPW_LOG : CPW_LOG;
    // Element index is wide enough that the shifted word offset covers all ADDR_W bits.
    localparam int E_W     = ADDR_W + EXTRA;

    typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, STREAM} state_t;
    state_t state, state_next;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // out_addr/out_lane/out_last stay stable while out_valid && !out_ready.
    logic              accept, reject, beat;
    logic              is_sprite_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        frame_q;
    logic [DIM_W-1:0]  height_q, width_q, x_q, y_q, rem_q;
    logic [23:0]       p_q;
    logic [E_W-1:0]    e_q;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign out_valid = (state == STREAM);
    assign beat      = out_valid && out_ready;
    assign out_last  = out_valid && (rem_q == DIM_W'(1));

`ifdef PIXEL_ADDR_GEN_BOUNDS_CHECK_EN
    logic [DIM_W:0] x_end;
    logic           err_q;
    assign x_end  = {1'b0, cmd_x} + {1'b0, cmd_len};
    assign reject = accept && cmd_is_sprite &&
                    ((cmd_y >= cmd_height) || (x_end > {1'b0, cmd_width}) ||
                     (cmd_width == '0) || (cmd_height == '0));
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= reject;
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !reject && (cmd_len != '0))
                    state_next = cmd_is_sprite ? MUL_A : STREAM;
            end
            MUL_A:  state_next = MUL_B;
            MUL_B:  state_next = STREAM;
            STREAM: begin
                if (beat && (rem_q == DIM_W'(1))) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            is_sprite_q <= 1'b0;
            base_q      <= '0;
            frame_q     <= '0;
            height_q    <= '0;
            width_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rem_q       <= '0;
            p_q         <= '0;
            e_q         <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                is_sprite_q <= cmd_is_sprite;
                base_q      <= cmd_base;
                frame_q     <= cmd_frame;
                height_q    <= cmd_height;
                width_q     <= cmd_width;
                x_q         <= cmd_x;
                y_q         <= cmd_y;
                rem_q       <= cmd_len;
                e_q         <= E_W'(cmd_index);
            end
            case (state)
                MUL_A: p_q <= 24'(frame_q) * 24'(height_q);
                // Row start plus x; high bits beyond the address range simply wrap away.
                MUL_B: e_q <= E_W'(p_q) * E_W'(width_q) + E_W'(y_q) * E_W'(width_q) + E_W'(x_q);
                STREAM: begin
                    if (beat) begin
                        e_q   <= e_q + E_W'(1);
                        rem_q <= rem_q - DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_addr = is_sprite_q ? base_q + ADDR_W'(e_q >> PPW_LOG)
                                  : base_q + ADDR_W'(e_q >> CPW_LOG);
    assign out_lane = is_sprite_q ? LANE_W'(e_q & E_W'(PPW - 1))
                                  : LANE_W'(e_q & E_W'(CPW - 1));
endmodule

// File: tb/tb_pixel_addr_gen.sv
// Directed bench for pixel_addr_gen: 16-bit-pixel and 4-bit-pixel instances share one stimulus bus.
module tb_pixel_addr_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_is_sprite, out_ready;
    logic [25:0] cmd_base;
    logic [7:0]  cmd_frame;
    logic [15:0] cmd_height, cmd_width, cmd_x, cmd_y, cmd_index, cmd_len;

    logic        a_ready, a_valid, a_last, a_err;
    logic [25:0] a_addr;
    logic [1:0]  a_lane;
    logic        b_ready, b_valid, b_last, b_err;
    logic [25:0] b_addr;
    logic [1:0]  b_lane;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_addr_gen #(.PIXEL_BITS(16)) u16 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_is_sprite(cmd_is_sprite), .cmd_base(cmd_base), .cmd_frame(cmd_frame),
        .cmd_height(cmd_height), .cmd_width(cmd_width), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_index(cmd_index), .cmd_len(cmd_len), .out_valid(a_valid), .out_ready(out_ready),
        .out_addr(a_addr), .out_lane(a_lane), .out_last(a_last), .err(a_err)
    );

    pixel_addr_gen #(.PIXEL_BITS(4)) u4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_is_sprite(cmd_is_sprite), .cmd_base(cmd_base), .cmd_frame(cmd_frame),
        .cmd_height(cmd_height), .cmd_width(cmd_width), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_index(cmd_index), .cmd_len(cmd_len), .out_valid(b_valid), .out_ready(out_ready),
        .out_addr(b_addr), .out_lane(b_lane), .out_last(b_last), .err(b_err)
    );

    typedef struct {
        logic             is_sprite;
        logic [25:0]      base;
        logic [7:0]       frame;
        logic [15:0]      h, w, x, y, index, len;
        int               sel;   // 0 = 16-bit-pixel instance, 1 = 4-bit-pixel instance
        int               lat;
        logic [3:0][25:0] addr;
        logic [3:0][1:0]  lane;
    } vec_t;

    vec_t vecs[6];

    function automatic logic f_valid(int sel); return (sel != 0) ? b_valid : a_valid; endfunction
    function automatic logic f_last(int sel);  return (sel != 0) ? b_last  : a_last;  endfunction
    function automatic logic [25:0] f_addr(int sel); return (sel != 0) ? b_addr : a_addr; endfunction
    function automatic logic [1:0]  f_lane(int sel); return (sel != 0) ? b_lane : a_lane; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic sp, input logic [25:0] base,
                           input logic [7:0] frame, input logic [15:0] h, input logic [15:0] w,
                           input logic [15:0] x, input logic [15:0] y, input logic [15:0] index,
                           input logic [15:0] len, input int sel, input int lat,
                           input logic [25:0] a0, input logic [25:0] a1,
                           input logic [25:0] a2, input logic [25:0] a3,
                           input logic [1:0] l0, input logic [1:0] l1,
                           input logic [1:0] l2, input logic [1:0] l3);
        vecs[i].is_sprite = sp;  vecs[i].base = base; vecs[i].frame = frame;
        vecs[i].h = h; vecs[i].w = w; vecs[i].x = x; vecs[i].y = y;
        vecs[i].index = index; vecs[i].len = len; vecs[i].sel = sel; vecs[i].lat = lat;
        vecs[i].addr = {a3, a2, a1, a0};
        vecs[i].lane = {l3, l2, l1, l0};
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send_cmd(input vec_t v);
        int n = 0;
        while (!(a_ready && b_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_send", {31'b0, a_ready && b_ready}, 32'd1);
        cmd_is_sprite = v.is_sprite; cmd_base = v.base; cmd_frame = v.frame;
        cmd_height = v.h; cmd_width = v.w; cmd_x = v.x; cmd_y = v.y;
        cmd_index = v.index; cmd_len = v.len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_first(input vec_t v);
        int lat = 1;
        while (!f_valid(v.sel) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_beat_latency", lat, v.lat);
    endtask

    task automatic run_beats(input vec_t v, input int stall_beat, input int stall_n);
        for (int k = 0; k < int'(v.len); k++) begin
            if (k == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    out_ready = 1'b0;
                    check("stall_valid", {31'b0, f_valid(v.sel)}, 32'd1);
                    check("stall_addr", {6'b0, f_addr(v.sel)}, {6'b0, v.addr[k]});
                    check("stall_lane", {30'b0, f_lane(v.sel)}, {30'b0, v.lane[k]});
                    check("stall_last", {31'b0, f_last(v.sel)}, {31'b0, k == int'(v.len) - 1});
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check("beat_valid", {31'b0, f_valid(v.sel)}, 32'd1);
            check("beat_addr", {6'b0, f_addr(v.sel)}, {6'b0, v.addr[k]});
            check("beat_lane", {30'b0, f_lane(v.sel)}, {30'b0, v.lane[k]});
            check("beat_last", {31'b0, f_last(v.sel)}, {31'b0, k == int'(v.len) - 1});
            @(negedge clk);
        end
        check("valid_after_last", {31'b0, f_valid(v.sel)}, 32'd0);
        check("ready_after_last", {31'b0, a_ready && b_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        // Expected values computed by hand from e = (frame*h + y)*w + x, addr = base + e/PPW.
        set_vec(0, 1, 26'h1000, 8'd2, 16'd4, 16'd8, 16'd3, 16'd1, 16'd0, 16'd3, 0, 3,
                26'h104B, 26'h104C, 26'h104D, 26'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        set_vec(1, 0, 26'h200, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd4, 0, 1,
                26'h202, 26'h203, 26'h203, 26'h204, 2'd1, 2'd0, 2'd1, 2'd0);
        set_vec(2, 1, 26'h300, 8'd0, 16'd4, 16'd16, 16'd2, 16'd0, 16'd0, 16'd4, 1, 3,
                26'h300, 26'h300, 26'h301, 26'h301, 2'd2, 2'd3, 2'd0, 2'd1);
        set_vec(3, 1, 26'h50, 8'd1, 16'd3, 16'd10, 16'd4, 16'd2, 16'd0, 16'd2, 0, 3,
                26'h86, 26'h87, 26'h0, 26'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        set_vec(4, 0, 26'h3FFFFFF, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd2, 1, 1,
                26'h0, 26'h1, 26'h0, 26'h0, 2'd1, 2'd0, 2'd0, 2'd0);
        set_vec(5, 1, 26'h10, 8'd1, 16'd2, 16'd8, 16'd6, 16'd1, 16'd0, 16'd2, 1, 3,
                26'h17, 26'h17, 26'h0, 26'h0, 2'd2, 2'd3, 2'd0, 2'd0);

        reset = 1'b1; cmd_valid = 1'b0; out_ready = 1'b1;
        cmd_is_sprite = 1'b0; cmd_base = '0; cmd_frame = '0; cmd_height = '0;
        cmd_width = '0; cmd_x = '0; cmd_y = '0; cmd_index = '0; cmd_len = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", {30'b0, a_valid, b_valid}, 32'd0);
        check("reset_ready", {30'b0, a_ready, b_ready}, 32'd0);
        check("reset_addr", {6'b0, a_addr}, 32'd0);
        check("reset_lane", {30'b0, a_lane}, 32'd0);
        check("reset_last", {30'b0, a_last, b_last}, 32'd0);
        check("reset_err", {30'b0, a_err, b_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {30'b0, a_ready, b_ready}, 32'd3);

        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i]);
            wait_first(vecs[i]);
            run_beats(vecs[i], -1, 0);
        end

        // Backpressure on the second beat for five cycles.
        send_cmd(vecs[0]);
        wait_first(vecs[0]);
        run_beats(vecs[0], 1, 5);

        // Reset while streaming, after the first beat has been taken.
        send_cmd(vecs[0]);
        wait_first(vecs[0]);
        check("rst_mid_beat1_addr", {6'b0, a_addr}, 32'h104B);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {30'b0, a_valid, b_valid}, 32'd0);
        check("rst_mid_last", {30'b0, a_last, b_last}, 32'd0);
        check("rst_mid_addr", {6'b0, a_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {30'b0, a_ready, b_ready}, 32'd3);

        // Zero-length command: accepted, no beats.
        v = vecs[1];
        v.len = 16'd0;
        send_cmd(v);
        for (int c = 0; c < 4; c++) begin
            check("len0_no_valid", {30'b0, a_valid, b_valid}, 32'd0);
            check("len0_ready", {30'b0, a_ready, b_ready}, 32'd3);
            @(negedge clk);
        end

        send_cmd(vecs[0]);
        wait_first(vecs[0]);
        run_beats(vecs[0], -1, 0);

`ifdef PIXEL_ADDR_GEN_BOUNDS_CHECK_EN
        v = vecs[0];
        v.y = 16'd4;
        send_cmd(v);
        check("bounds_err_pulse", {30'b0, a_err, b_err}, 32'd3);
        @(negedge clk);
        check("bounds_err_clear", {30'b0, a_err, b_err}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("bounds_no_valid", {30'b0, a_valid, b_valid}, 32'd0);
            @(negedge clk);
        end
        send_cmd(vecs[0]);
        check("bounds_valid_no_err", {30'b0, a_err, b_err}, 32'd0);
        wait_first(vecs[0]);
        run_beats(vecs[0], -1, 0);
`else
        check("err_tied_low", {30'b0, a_err, b_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
